// File: rtl/rgb_fade.sv
// rtl/rgb_fade.sv - three-channel active-low PWM LED fader with ramped duty
// Each request input ramps its channel duty toward full-on or off at a slow tick rate.
module rgb_fade #(
  parameter logic [31:0] FADE_DIV = 32'd23437,
  parameter logic [7:0]  STEP     = 8'd1
) (
  input  logic clk,
  input  logic rst,
  input  logic r_in,
  input  logic g_in,
  input  logic b_in,
  output logic r,
  output logic g,
  output logic b,
  output logic idle
);

  // Channel index 0 = red, 1 = green, 2 = blue throughout.
  logic [2:0]      req_s1;
  logic [2:0]      req_s2;
  logic [31:0]     div_cnt;
  logic            tick;
  logic [7:0]      pwm_cnt;
  logic [2:0][7:0] work;
  logic [2:0][7:0] act;
  logic [2:0][7:0] target;
  logic [2:0][7:0] work_next;
  logic [2:0][8:0] up_sum;
  logic [2:0][8:0] dn_dif;
  logic [2:0]      at_target;
  logic [2:0]      pwm_out;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_s1 <= 3'b111;
      req_s2 <= 3'b111;
    end else begin
      req_s1 <= {b_in, g_in, r_in};
      req_s2 <= req_s1;
    end
  end

  assign tick = (div_cnt == FADE_DIV);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= 32'd0;
    end else if (tick) begin
      div_cnt <= 32'd0;
    end else begin
      div_cnt <= div_cnt + 32'd1;
    end
  end

  // Ramp arithmetic is done one bit wider so overflow/underflow can be clamped.
  always_comb begin
    target    = '0;
    work_next = work;
    up_sum    = '0;
    dn_dif    = '0;
    at_target = '0;
    pwm_out   = '1;
    for (int i = 0; i < 3; i++) begin
      target[i] = req_s2[i] ? 8'd0 : 8'd255;
      up_sum[i] = {1'b0, work[i]} + {1'b0, STEP};
      dn_dif[i] = {1'b0, work[i]} - {1'b0, STEP};
      if (work[i] < target[i]) begin
        work_next[i] = up_sum[i][8] ? 8'd255 : up_sum[i][7:0];
      end else if (work[i] > target[i]) begin
        work_next[i] = dn_dif[i][8] ? 8'd0 : dn_dif[i][7:0];
      end
      at_target[i] = (work[i] == target[i]);
      pwm_out[i]   = !((act[i] == 8'd255) || (pwm_cnt < act[i]));
    end
    idle = &at_target;
  end

  // Active duty only follows the working duty at the period boundary so a
  // PWM period is never split between two duty values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      work    <= '0;
      act     <= '0;
      pwm_cnt <= 8'd0;
      r       <= 1'b1;
      g       <= 1'b1;
      b       <= 1'b1;
    end else begin
      if (tick) begin
        work <= work_next;
      end
      if (pwm_cnt == 8'hFF) begin
        act <= work;
      end
      pwm_cnt <= pwm_cnt + 8'd1;
      r       <= pwm_out[0];
      g       <= pwm_out[1];
      b       <= pwm_out[2];
    end
  end

endmodule

// File: tb/tb_rgb_fade.sv
// tb/tb_rgb_fade.sv - directed bench for rgb_fade ramps, PWM shape and reset
// dut ramps every 4 cycles by 64; dut2 ticks every 300 cycles to hold a duty for a full period.
module tb_rgb_fade;

  logic clk = 1'b0;
  logic rst, r_in, g_in, b_in, r, g, b, idle;
  logic rst2, r_in2, g_in2, b_in2, r2, g2, b2, idle2;
  int checks = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rgb_fade #(.FADE_DIV(32'd3), .STEP(8'd64)) dut (
    .clk(clk), .rst(rst), .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .r(r), .g(g), .b(b), .idle(idle)
  );

  rgb_fade #(.FADE_DIV(32'd299), .STEP(8'd64)) dut2 (
    .clk(clk), .rst(rst2), .r_in(r_in2), .g_in(g_in2), .b_in(b_in2),
    .r(r2), .g(g2), .b(b2), .idle(idle2)
  );

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Leaves the bench at a negedge with reset just released: next posedge is edge 1.
  task automatic restart(input logic ri, input logic gi, input logic bi);
    @(negedge clk);
    rst = 1'b0;
    r_in = ri; g_in = gi; b_in = bi;
    cyc(2);
    rst = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b0; r_in = 1'b1; g_in = 1'b1; b_in = 1'b1;
    cyc(3);
    checks++;
    if ({r, g, b} !== 3'b111) begin fails++; $display("FAIL reset_out: got %b expected 111", {r, g, b}); end
    checks++;
    if (idle !== 1'b1) begin fails++; $display("FAIL reset_idle: got %b expected 1", idle); end
    checks++;
    if (dut.pwm_cnt !== 8'd0) begin fails++; $display("FAIL reset_pwm: got %0d expected 0", dut.pwm_cnt); end
    rst = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      cyc(1);
      checks++;
      if (dut.pwm_cnt !== 8'(k)) begin fails++; $display("FAIL reset_pwm_seq edge %0d: got %0d expected %0d", k, dut.pwm_cnt, k); end
      checks++;
      if ({r, g, b, idle} !== 4'b1111) begin fails++; $display("FAIL reset_hold edge %0d: got %b expected 1111", k, {r, g, b, idle}); end
    end
  endtask

  task automatic test_ramp_up;
    logic [7:0] exp_w;
    logic exp_i;
    restart(1'b0, 1'b1, 1'b1);
    for (int k = 1; k <= 20; k++) begin
      cyc(1);
      exp_w = (k < 4) ? 8'd0 : (k < 8) ? 8'd64 : (k < 12) ? 8'd128 : (k < 16) ? 8'd192 : 8'd255;
      exp_i = (k < 2) || (k >= 16);
      checks++;
      if (dut.work[0] !== exp_w) begin fails++; $display("FAIL up_duty edge %0d: got %0d expected %0d", k, dut.work[0], exp_w); end
      checks++;
      if (idle !== exp_i) begin fails++; $display("FAIL up_idle edge %0d: got %b expected %b", k, idle, exp_i); end
      checks++;
      if ({r, g, b} !== 3'b111) begin fails++; $display("FAIL up_out edge %0d: got %b expected 111", k, {r, g, b}); end
    end
    cyc(236);
    checks++;
    if (dut.act[0] !== 8'd255) begin fails++; $display("FAIL up_act: got %0d expected 255", dut.act[0]); end
    for (int k = 257; k <= 520; k++) begin
      cyc(1);
      checks++;
      if ({r, g, b} !== 3'b011) begin fails++; $display("FAIL full_on edge %0d: got %b expected 011", k, {r, g, b}); end
    end
  endtask

  task automatic test_ramp_down;
    logic [7:0] exp_w;
    logic exp_i;
    restart(1'b0, 1'b1, 1'b1);
    cyc(20);
    r_in = 1'b1;
    for (int k = 21; k <= 44; k++) begin
      cyc(1);
      exp_w = (k < 24) ? 8'd255 : (k < 28) ? 8'd191 : (k < 32) ? 8'd127 : (k < 36) ? 8'd63 : 8'd0;
      exp_i = (k == 21) || (k >= 36);
      checks++;
      if (dut.work[0] !== exp_w) begin fails++; $display("FAIL down_duty edge %0d: got %0d expected %0d", k, dut.work[0], exp_w); end
      checks++;
      if (idle !== exp_i) begin fails++; $display("FAIL down_idle edge %0d: got %b expected %b", k, idle, exp_i); end
    end
  endtask

  task automatic test_reverse;
    logic [7:0] exp_w;
    restart(1'b0, 1'b1, 1'b1);
    cyc(8);
    checks++;
    if (dut.work[0] !== 8'd128) begin fails++; $display("FAIL rev_start: got %0d expected 128", dut.work[0]); end
    r_in = 1'b1;
    for (int k = 9; k <= 12; k++) begin
      cyc(1);
      exp_w = (k < 12) ? 8'd128 : 8'd64;
      checks++;
      if (dut.work[0] !== exp_w) begin fails++; $display("FAIL rev_down edge %0d: got %0d expected %0d", k, dut.work[0], exp_w); end
    end
    r_in = 1'b0;
    for (int k = 13; k <= 24; k++) begin
      cyc(1);
      exp_w = (k < 16) ? 8'd64 : (k < 20) ? 8'd128 : (k < 24) ? 8'd192 : 8'd255;
      checks++;
      if (dut.work[0] !== exp_w) begin fails++; $display("FAIL rev_up edge %0d: got %0d expected %0d", k, dut.work[0], exp_w); end
    end
  endtask

  task automatic test_independent;
    logic [7:0] exp_r, exp_b;
    restart(1'b0, 1'b1, 1'b0);
    cyc(8);
    b_in = 1'b1;
    for (int k = 9; k <= 16; k++) begin
      cyc(1);
      exp_r = (k < 12) ? 8'd128 : (k < 16) ? 8'd192 : 8'd255;
      exp_b = (k < 12) ? 8'd128 : (k < 16) ? 8'd64 : 8'd0;
      checks++;
      if ({dut.work[0], dut.work[1], dut.work[2]} !== {exp_r, 8'd0, exp_b})
        begin fails++; $display("FAIL indep edge %0d: got r%0d g%0d b%0d expected r%0d g0 b%0d", k, dut.work[0], dut.work[1], dut.work[2], exp_r, exp_b); end
    end
  endtask

  task automatic test_tick_wrap;
    int lows;
    restart(1'b0, 1'b1, 1'b1);
    cyc(246);
    r_in = 1'b1;
    cyc(6);
    checks++;
    if (dut.work[0] !== 8'd191) begin fails++; $display("FAIL wrap_pre: got %0d expected 191", dut.work[0]); end
    cyc(4);
    checks++;
    if (dut.work[0] !== 8'd127) begin fails++; $display("FAIL wrap_work: got %0d expected 127", dut.work[0]); end
    checks++;
    if (dut.act[0] !== 8'd191) begin fails++; $display("FAIL wrap_act: got %0d expected 191", dut.act[0]); end
    lows = 0;
    for (int k = 257; k <= 512; k++) begin
      cyc(1);
      if (r === 1'b0) lows++;
      if (k == 257) begin
        checks++;
        if (r !== 1'b0) begin fails++; $display("FAIL wrap_first_low: got %b expected 0", r); end
      end
    end
    checks++;
    if (lows != 191) begin fails++; $display("FAIL wrap_low_count: got %0d expected 191", lows); end
    checks++;
    if (dut.act[0] !== 8'd0) begin fails++; $display("FAIL wrap_next_act: got %0d expected 0", dut.act[0]); end
    for (int k = 513; k <= 530; k++) begin
      cyc(1);
      checks++;
      if (r !== 1'b1) begin fails++; $display("FAIL dark edge %0d: got %b expected 1", k, r); end
    end
  endtask

  task automatic test_pwm_64;
    int lows;
    logic exp_o;
    @(negedge clk);
    rst2 = 1'b0; r_in2 = 1'b0; g_in2 = 1'b1; b_in2 = 1'b1;
    cyc(2);
    rst2 = 1'b1;
    cyc(300);
    checks++;
    if (dut2.work[0] !== 8'd64) begin fails++; $display("FAIL pwm64_work: got %0d expected 64", dut2.work[0]); end
    cyc(212);
    checks++;
    if (dut2.act[0] !== 8'd64) begin fails++; $display("FAIL pwm64_act: got %0d expected 64", dut2.act[0]); end
    lows = 0;
    for (int k = 513; k <= 768; k++) begin
      cyc(1);
      exp_o = (k > 576);
      if (r2 === 1'b0) lows++;
      checks++;
      if ({r2, g2, b2} !== {exp_o, 2'b11}) begin fails++; $display("FAIL pwm64_out edge %0d: got %b expected %b11", k, {r2, g2, b2}, exp_o); end
    end
    checks++;
    if (lows != 64) begin fails++; $display("FAIL pwm64_low_count: got %0d expected 64", lows); end
  endtask

  task automatic test_reset_mid;
    logic [7:0] exp_w;
    restart(1'b0, 1'b1, 1'b1);
    cyc(260);
    checks++;
    if (r !== 1'b0) begin fails++; $display("FAIL mid_pre_r: got %b expected 0", r); end
    rst = 1'b0;
    #1;
    checks++;
    if ({r, g, b, idle} !== 4'b1111) begin fails++; $display("FAIL mid_async_out: got %b expected 1111", {r, g, b, idle}); end
    checks++;
    if ({dut.work[0], dut.act[0], dut.pwm_cnt} !== 24'd0) begin fails++; $display("FAIL mid_async_state: got w%0d a%0d p%0d expected 0", dut.work[0], dut.act[0], dut.pwm_cnt); end
    @(negedge clk);
    rst = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      cyc(1);
      exp_w = (k < 4) ? 8'd0 : (k < 8) ? 8'd64 : 8'd128;
      checks++;
      if (dut.work[0] !== exp_w) begin fails++; $display("FAIL mid_resume edge %0d: got %0d expected %0d", k, dut.work[0], exp_w); end
      checks++;
      if (dut.pwm_cnt !== 8'(k)) begin fails++; $display("FAIL mid_pwm edge %0d: got %0d expected %0d", k, dut.pwm_cnt, k); end
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({dut.work[0], idle, r} !== {8'd0, 2'b11}) begin fails++; $display("FAIL mid128_clear: got w%0d idle%b r%b expected w0 idle1 r1", dut.work[0], idle, r); end
    @(negedge clk);
    rst = 1'b1;
    cyc(3);
    checks++;
    if (dut.work[0] !== 8'd0) begin fails++; $display("FAIL mid128_no_stale_tick: got %0d expected 0", dut.work[0]); end
    cyc(1);
    checks++;
    if (dut.work[0] !== 8'd64) begin fails++; $display("FAIL mid128_restart: got %0d expected 64", dut.work[0]); end
  endtask

  initial begin
    rst2 = 1'b0; r_in2 = 1'b1; g_in2 = 1'b1; b_in2 = 1'b1;
    test_reset;
    test_ramp_up;
    test_ramp_down;
    test_reverse;
    test_independent;
    test_tick_wrap;
    test_pwm_64;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
